// File: rtl/ssd1306_pkg.sv
// Shared opcodes, addressing modes and decoder states
// for the SSD1306 command decoder slice.
package ssd1306_pkg;

  localparam int COLUMNS_DEF = 128;
  localparam int PAGES_DEF   = 8;

  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_NORMAL     = 8'hA6;
  localparam logic [7:0] OP_INVERT     = 8'hA7;
  localparam logic [7:0] OP_RAM_SHOW   = 8'hA4;
  localparam logic [7:0] OP_ALL_ON     = 8'hA5;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_MODE       = 8'h20;
  localparam logic [7:0] OP_COL_RANGE  = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE = 8'h22;

  typedef enum logic [1:0] {
    MODE_HORZ = 2'b00,
    MODE_VERT = 2'b01,
    MODE_PAGE = 2'b10
  } addr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG1 = 2'd1,
    ARG2 = 2'd2
  } state_e;

endpackage

// File: rtl/ssd1306_addr_pointer.sv
// Column/page write pointer with mode-dependent
// advance and wrap inside the programmed ranges.
module ssd1306_addr_pointer
  import ssd1306_pkg::*;
#(
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int PAGES   = PAGES_DEF,
  parameter int CW      = $clog2(COLUMNS),
  parameter int PW      = $clog2(PAGES)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  addr_mode_e    mode,
  input  logic [CW-1:0] col_start,
  input  logic [CW-1:0] col_end,
  input  logic [PW-1:0] page_start,
  input  logic [PW-1:0] page_end,
  input  logic          load_col,
  input  logic [CW-1:0] load_col_val,
  input  logic          load_page,
  input  logic [PW-1:0] load_page_val,
  input  logic          advance,
  output logic [CW-1:0] column,
  output logic [PW-1:0] page
);

  localparam logic [CW-1:0] COL_MAX  = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] PAGE_MAX = PW'(PAGES - 1);

  logic          col_eor;
  logic          page_eor;
  logic [CW-1:0] col_n;
  logic [PW-1:0] page_n;

  // The array limit also counts as end-of-range so start > end stays in bounds
  assign col_eor  = (column == col_end) || (column == COL_MAX);
  assign page_eor = (page == page_end) || (page == PAGE_MAX);

  always_comb begin
    col_n  = column;
    page_n = page;
    if (advance) begin
      case (mode)
        MODE_HORZ: begin
          if (col_eor) begin
            col_n  = col_start;
            page_n = page_eor ? page_start : page + 1'b1;
          end else begin
            col_n = column + 1'b1;
          end
        end
        MODE_VERT: begin
          if (page_eor) begin
            page_n = page_start;
            col_n  = col_eor ? col_start : column + 1'b1;
          end else begin
            page_n = page + 1'b1;
          end
        end
        default: begin
          col_n = (column == COL_MAX) ? '0 : column + 1'b1;
        end
      endcase
    end
    if (load_col) col_n = load_col_val;
    if (load_page) page_n = load_page_val;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      column <= '0;
      page   <= '0;
    end else begin
      column <= col_n;
      page   <= page_n;
    end
  end

endmodule

// File: rtl/ssd1306_cmd_decoder.sv
// SSD1306-style SPI command/data decoder driving
// framebuffer writes and panel configuration.
module ssd1306_cmd_decoder
  import ssd1306_pkg::*;
#(
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int PAGES   = PAGES_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Byte_i,
  input  logic       ByteValid_i,
  input  logic       DC_i,
  input  logic       CS_i,
  output logic [$clog2(PAGES)+$clog2(COLUMNS)-1:0] FbAddr_o,
  output logic [7:0] FbData_o,
  output logic       FbWrite_o,
  output logic       DisplayOn_o,
  output logic       Invert_o,
  output logic       AllOn_o,
  output logic [7:0] Contrast_o,
  output logic       UnknownCmd_o
);

  localparam int CW = $clog2(COLUMNS);
  localparam int PW = $clog2(PAGES);

  state_e        state;
  logic [7:0]    opcode_q;
  logic [CW-1:0] arg_q;
  addr_mode_e    mode;
  logic [CW-1:0] col_start;
  logic [CW-1:0] col_end;
  logic [PW-1:0] page_start;
  logic [PW-1:0] page_end;
  logic [CW-1:0] column;
  logic [PW-1:0] page;

  logic          accept;
  logic          is_data;
  logic          is_cmd;
  logic          op_col_lo;
  logic          op_col_hi;
  logic          op_page;
  logic          known;
  logic          ld_col;
  logic [CW-1:0] ld_col_val;
  logic          ld_page;
  logic [PW-1:0] ld_page_val;

  assign accept    = ByteValid_i & ~CS_i;
  assign is_data   = accept & DC_i;
  assign is_cmd    = accept & ~DC_i;
  assign op_col_lo = Byte_i[7:4] == 4'h0;
  assign op_col_hi = Byte_i[7:3] == 5'b00010;
  assign op_page   = Byte_i[7:3] == 5'b10110;

  assign known = op_col_lo || op_col_hi || op_page ||
    (Byte_i inside {OP_DISP_OFF, OP_DISP_ON,
                    OP_NORMAL, OP_INVERT,
                    OP_RAM_SHOW, OP_ALL_ON,
                    OP_CONTRAST, OP_MODE,
                    OP_COL_RANGE, OP_PAGE_RANGE});

  always_comb begin
    ld_col      = 1'b0;
    ld_col_val  = column;
    ld_page     = 1'b0;
    ld_page_val = page;
    if (is_cmd) begin
      unique case (state)
        IDLE: begin
          if (op_col_lo) begin
            ld_col     = 1'b1;
            ld_col_val = {column[CW-1:4], Byte_i[3:0]};
          end else if (op_col_hi) begin
            ld_col     = 1'b1;
            ld_col_val = {Byte_i[CW-5:0], column[3:0]};
          end else if (op_page) begin
            ld_page     = 1'b1;
            ld_page_val = Byte_i[PW-1:0];
          end
        end
        ARG2: begin
          if (opcode_q == OP_COL_RANGE) begin
            ld_col     = 1'b1;
            ld_col_val = arg_q;
          end else if (opcode_q == OP_PAGE_RANGE) begin
            ld_page     = 1'b1;
            ld_page_val = arg_q[PW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  ssd1306_addr_pointer #(
    .COLUMNS (COLUMNS),
    .PAGES   (PAGES)
  ) u_ptr (
    .Clock         (Clock),
    .Reset         (Reset),
    .mode          (mode),
    .col_start     (col_start),
    .col_end       (col_end),
    .page_start    (page_start),
    .page_end      (page_end),
    .load_col      (ld_col),
    .load_col_val  (ld_col_val),
    .load_page     (ld_page),
    .load_page_val (ld_page_val),
    .advance       (is_data),
    .column        (column),
    .page          (page)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      opcode_q     <= '0;
      arg_q        <= '0;
      mode         <= MODE_PAGE;
      col_start    <= '0;
      col_end      <= CW'(COLUMNS - 1);
      page_start   <= '0;
      page_end     <= PW'(PAGES - 1);
      FbAddr_o     <= '0;
      FbData_o     <= '0;
      FbWrite_o    <= 1'b0;
      DisplayOn_o  <= 1'b0;
      Invert_o     <= 1'b0;
      AllOn_o      <= 1'b0;
      Contrast_o   <= 8'h7F;
      UnknownCmd_o <= 1'b0;
    end else begin
      FbWrite_o    <= 1'b0;
      UnknownCmd_o <= 1'b0;
      if (is_data) begin
        FbWrite_o <= 1'b1;
        FbAddr_o  <= {page, column};
        FbData_o  <= Byte_i;
      end
      // Deselect or a data byte abandons any half-received command
      if (CS_i || is_data) begin
        state <= IDLE;
      end else if (is_cmd) begin
        unique case (state)
          IDLE: begin
            case (Byte_i)
              OP_DISP_OFF: DisplayOn_o <= 1'b0;
              OP_DISP_ON:  DisplayOn_o <= 1'b1;
              OP_NORMAL:   Invert_o <= 1'b0;
              OP_INVERT:   Invert_o <= 1'b1;
              OP_RAM_SHOW: AllOn_o <= 1'b0;
              OP_ALL_ON:   AllOn_o <= 1'b1;
              OP_CONTRAST, OP_MODE,
              OP_COL_RANGE, OP_PAGE_RANGE: begin
                opcode_q <= Byte_i;
                state    <= ARG1;
              end
              default: UnknownCmd_o <= ~known;
            endcase
          end
          ARG1: begin
            state <= IDLE;
            if (opcode_q == OP_CONTRAST) begin
              Contrast_o <= Byte_i;
            end else if (opcode_q == OP_MODE) begin
              if (Byte_i[1:0] != 2'b11)
                mode <= addr_mode_e'(Byte_i[1:0]);
            end else begin
              arg_q <= Byte_i[CW-1:0];
              state <= ARG2;
            end
          end
          ARG2: begin
            state <= IDLE;
            if (opcode_q == OP_COL_RANGE) begin
              col_start <= arg_q;
              col_end   <= Byte_i[CW-1:0];
            end else if (opcode_q == OP_PAGE_RANGE) begin
              page_start <= arg_q[PW-1:0];
              page_end   <= Byte_i[PW-1:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_cmd_decoder.sv
// Randomized and directed bench for ssd1306_cmd_decoder
// against a byte-level behavioural display model.
module tb_ssd1306_cmd_decoder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Byte_i = '0;
  logic       ByteValid_i = 1'b0;
  logic       DC_i = 1'b0;
  logic       CS_i = 1'b0;
  logic [9:0] FbAddr_o;
  logic [7:0] FbData_o;
  logic       FbWrite_o;
  logic       DisplayOn_o;
  logic       Invert_o;
  logic       AllOn_o;
  logic [7:0] Contrast_o;
  logic       UnknownCmd_o;

  always #5 Clock = ~Clock;

  ssd1306_cmd_decoder dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Byte_i       (Byte_i),
    .ByteValid_i  (ByteValid_i),
    .DC_i         (DC_i),
    .CS_i         (CS_i),
    .FbAddr_o     (FbAddr_o),
    .FbData_o     (FbData_o),
    .FbWrite_o    (FbWrite_o),
    .DisplayOn_o  (DisplayOn_o),
    .Invert_o     (Invert_o),
    .AllOn_o      (AllOn_o),
    .Contrast_o   (Contrast_o),
    .UnknownCmd_o (UnknownCmd_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural display model
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode;
  int m_op, m_nargs, m_a1;
  int m_disp, m_inv, m_all, m_con;
  int e_wr, e_unk, e_addr, e_data;
  int seen[$];
  int obs_unk;

  function automatic void m_reset();
    m_col = 0; m_page = 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_mode = 2; m_op = 0; m_nargs = 0; m_a1 = 0;
    m_disp = 0; m_inv = 0; m_all = 0; m_con = 'h7F;
    e_wr = 0; e_unk = 0; e_addr = 0; e_data = 0;
  endfunction

  function automatic void m_advance();
    bit ce, pe;
    ce = (m_col == m_ce) || (m_col == 127);
    pe = (m_page == m_pe) || (m_page == 7);
    if (m_mode == 0) begin
      if (ce) begin
        m_col = m_cs;
        m_page = pe ? m_ps : m_page + 1;
      end else m_col++;
    end else if (m_mode == 1) begin
      if (pe) begin
        m_page = m_ps;
        m_col = ce ? m_cs : m_col + 1;
      end else m_page++;
    end else begin
      m_col = (m_col + 1) % 128;
    end
  endfunction

  function automatic void m_byte(bit v, int b, bit dc, bit cs);
    e_wr = 0;
    e_unk = 0;
    if (cs) begin
      m_op = 0;
      m_nargs = 0;
      return;
    end
    if (!v) return;
    if (dc) begin
      m_op = 0;
      m_nargs = 0;
      e_wr = 1;
      e_addr = m_page * 128 + m_col;
      e_data = b;
      m_advance();
      return;
    end
    if (m_op == 0) begin
      if (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b == 'hA4) m_all = 0;
      else if (b == 'hA5) m_all = 1;
      else if (b == 'h81 || b == 'h20 || b == 'h21 || b == 'h22)
        m_op = b;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 'h10 && b <= 'h17)
        m_col = (b - 'h10) * 16 + m_col % 16;
      else e_unk = 1;
    end else if (m_op == 'h81) begin
      m_con = b;
      m_op = 0;
    end else if (m_op == 'h20) begin
      if (b % 4 != 3) m_mode = b % 4;
      m_op = 0;
    end else if (m_nargs == 0) begin
      m_a1 = b;
      m_nargs = 1;
    end else begin
      if (m_op == 'h21) begin
        m_cs = m_a1 % 128; m_ce = b % 128; m_col = m_cs;
      end else begin
        m_ps = m_a1 % 8; m_pe = b % 8; m_page = m_ps;
      end
      m_op = 0;
      m_nargs = 0;
    end
  endfunction

  task automatic observe();
    chk("wr", FbWrite_o, e_wr);
    if (e_wr) begin
      chk("addr", FbAddr_o, e_addr);
      chk("data", FbData_o, e_data);
    end
    chk("unk", UnknownCmd_o, e_unk);
    chk("disp", DisplayOn_o, m_disp);
    chk("inv", Invert_o, m_inv);
    chk("allon", AllOn_o, m_all);
    chk("con", Contrast_o, m_con);
    if (FbWrite_o) seen.push_back(int'(FbAddr_o));
    obs_unk = UnknownCmd_o;
  endtask

  // One cycle: check the previous byte's effect, then drive the next
  task automatic step(bit v, logic [7:0] b, bit dc, bit cs);
    @(negedge Clock);
    observe();
    ByteValid_i = v;
    Byte_i = b;
    DC_i = dc;
    CS_i = cs;
    m_byte(v, int'(b), dc, cs);
  endtask

  task automatic cmd(logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic dat(logic [7:0] b);
    step(1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ByteValid_i = 1'b0;
    CS_i = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rst_disp", DisplayOn_o, 0);
    chk("rst_inv", Invert_o, 0);
    chk("rst_all", AllOn_o, 0);
    chk("rst_con", Contrast_o, 'h7F);
    chk("rst_addr", FbAddr_o, 0);
    chk("rst_data", FbData_o, 0);
    chk("rst_wr", FbWrite_o, 0);
    chk("rst_unk", UnknownCmd_o, 0);
    m_reset();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  function automatic int seen_at(int i);
    return (i < seen.size()) ? seen[i] : -1;
  endfunction

  logic [7:0] tbl [24] = '{
    8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'hA4, 8'hA5,
    8'h81, 8'h20, 8'h21, 8'h22, 8'hB0, 8'hB5,
    8'hB7, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0F,
    8'h10, 8'h17, 8'h7E, 8'h7F, 8'h05, 8'h33
  };

  initial begin
    m_reset();
    do_reset();

    // First write after reset lands at 0, the next at 1
    seen.delete();
    dat(8'h55);
    idle();
    chk("first_addr", FbAddr_o, 'h000);
    chk("first_data", FbData_o, 'h55);
    dat(8'h56);
    idle();
    chk("second_addr", seen_at(1), 'h001);

    // Horizontal mode with a 2x2 window in the corner
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h7E); cmd(8'h7F);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    seen.delete();
    for (int i = 0; i < 5; i++) dat(8'(i));
    idle();
    chk("h0", seen_at(0), 'h37E);
    chk("h1", seen_at(1), 'h37F);
    chk("h2", seen_at(2), 'h3FE);
    chk("h3", seen_at(3), 'h3FF);
    chk("h4", seen_at(4), 'h37E);

    // Vertical mode
    cmd(8'h20); cmd(8'h01);
    cmd(8'h22); cmd(8'h00); cmd(8'h01);
    cmd(8'h21); cmd(8'h05); cmd(8'h06);
    seen.delete();
    for (int i = 0; i < 3; i++) dat(8'hA0);
    idle();
    chk("v0", seen_at(0), 'h005);
    chk("v1", seen_at(1), 'h085);
    chk("v2", seen_at(2), 'h006);

    // Deselect abandons a pending contrast argument
    cmd(8'h81);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    cmd(8'h33);
    idle();
    chk("cs_con", Contrast_o, 'h7F);
    chk("cs_unk", obs_unk, 1);

    // Single-byte settings and pointer commands
    do_reset();
    cmd(8'hAF); cmd(8'hA7); cmd(8'hA5);
    cmd(8'hB3); cmd(8'h0A); cmd(8'h12);
    seen.delete();
    dat(8'hFF);
    idle();
    chk("cfg_disp", DisplayOn_o, 1);
    chk("cfg_inv", Invert_o, 1);
    chk("cfg_all", AllOn_o, 1);
    chk("cfg_addr", seen_at(0), 'h1AA);

    // Reset in the middle of a column-range command
    cmd(8'h21); cmd(8'h10);
    do_reset();
    dat(8'h11);
    dat(8'h22);
    idle();

    // Randomized traffic, including start > end ranges
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      bit v, dc, cs;
      if (i % 1000 == 999) do_reset();
      cs = ($urandom % 20) == 0;
      v  = ($urandom % 6) != 0;
      dc = ($urandom % 3) == 0;
      if ($urandom % 4 == 0) b = 8'($urandom);
      else b = tbl[$urandom % 24];
      step(v, b, dc, cs);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ssd1306_cmd_decoder.md
SSD1306_CMD_DECODER -- requirements
Module: ssd1306_cmd_decoder

Interface
REQ-001 Parameters SHALL be: COLUMNS, 128, framebuffer columns; PAGES, 8, framebuffer pages of 8 rows; FbAddr_o width = clog2(PAGES)+clog2(COLUMNS) = 10.
REQ-002 Ports SHALL be, in order:
 Clock  in  1  sole clock, rising edge;
 Reset  in  1  asynchronous, active-low;
 Byte_i  in  8  received SPI byte;
 ByteValid_i  in  1  one-cycle strobe, Byte_i/DC_i valid;
 DC_i  in  1  0 = command byte, 1 = data byte;
 CS_i  in  1  SPI chip select, high = deselected;
 FbAddr_o  out  10  framebuffer address {page[2:0], column[6:0]};
 FbData_o  out  8  framebuffer write data;
 FbWrite_o  out  1  one-cycle write strobe;
 DisplayOn_o  out  1  panel enabled;
 Invert_o  out  1  pixel inversion;
 AllOn_o  out  1  entire display lit;
 Contrast_o  out  8  contrast level;
 UnknownCmd_o  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-003 FSM states SHALL be IDLE, ARG1, ARG2; pending opcode held in a register.
REQ-004 Single-byte commands in IDLE: 0xAE/0xAF -> DisplayOn 0/1; 0xA6/0xA7 -> Invert 0/1; 0xA4/0xA5 -> AllOn 0/1; 0xB0-0xB7 -> page pointer = byte[2:0]; 0x00-0x0F -> column[3:0] = byte[3:0]; 0x10-0x17 -> column[6:4] = byte[2:0].
REQ-005 0x81 and 0x20 SHALL go to ARG1; the next command byte SHALL set Contrast_o (0x81) or addressing mode = arg[1:0] (0x20; 00 horizontal, 01 vertical, 10 page, 11 ignored, mode unchanged); then IDLE.
REQ-006 0x21 SHALL take ARG1 = column start (arg[6:0]), ARG2 = column end; on ARG2 column pointer SHALL load column start; 0x22 likewise with page start/end (arg[2:0]) and page pointer.
REQ-007 Any other command opcode SHALL pulse UnknownCmd_o one cycle, no state change.
REQ-008 Data byte in any state SHALL produce FbWrite_o=1 exactly one cycle after the ByteValid_i cycle, with FbAddr_o = current pointers and FbData_o = Byte_i; pointers advance in the same update.
REQ-009 Data byte in ARG1/ARG2 SHALL abort the pending command (no register changes) and return to IDLE, then be written per REQ-008.
REQ-010 Horizontal advance: column at end-of-range -> column = column start and page advances (page at end-of-range -> page start); else column+1.
REQ-011 Vertical advance: page at end-of-range -> page = page start and column advances (column at end-of-range -> column start); else page+1.
REQ-012 Page-mode advance: column = 127 -> column 0, page unchanged; else column+1.
REQ-013 End-of-range SHALL mean pointer == range end OR pointer == maximum (127 / 7), so start > end never runs off the array.
REQ-014 ByteValid_i while CS_i = 1 SHALL be ignored; CS_i = 1 at any time SHALL force IDLE, pointers and settings kept.
REQ-015 Config outputs SHALL update one cycle after the completing byte's ByteValid_i; back-to-back ByteValid_i every cycle SHALL be supported without loss.

Reset
REQ-016 Reset low SHALL asynchronously force: IDLE, DisplayOn_o 0, Invert_o 0, AllOn_o 0, Contrast_o 0x7F, mode page, column range 0-127, page range 0-7, pointers 0, FbAddr_o 0, FbData_o 0, FbWrite_o 0, UnknownCmd_o 0.
REQ-017 Reset mid-command SHALL discard the pending opcode and arguments.

Structure
REQ-018 Package ssd1306_pkg SHALL hold opcode constants, addressing-mode typedef, FSM state typedef, COLUMNS/PAGES defaults.
REQ-019 Pointer advance/wrap logic SHALL be sub-module ssd1306_addr_pointer (mode, ranges, load, advance in; column/page out).

Verification
REQ-020 Reset release, data 0x55 -> FbWrite_o pulse, FbAddr_o 0x000, FbData_o 0x55, next write at 0x001.
REQ-021 0x20,0x00; 0x21,0x7E,0x7F; 0x22,0x06,0x07; five data bytes -> addresses 0x37E,0x37F,0x3FE,0x3FF,0x37E.
REQ-022 0x20,0x01; 0x22,0x00,0x01; 0x21,0x05,0x06; three data -> 0x005,0x085,0x006.
REQ-023 0x81 then CS_i high then 0x33 with DC=0 -> Contrast_o stays 0x7F, UnknownCmd_o pulses (0x33 decoded as opcode).
REQ-024 0xAF,0xA7,0xA5,0xB3,0x0A,0x12, data 0xFF -> DisplayOn/Invert/AllOn = 1, write at 0x1AA; reset asserted mid-0x21 -> all REQ-016 values.
